// File: rtl/lfsr_prng.sv
// lfsr_prng: WIDTH-bit XNOR Fibonacci LFSR with seed load, wrap/step tracking and threshold compare.
// Latency: en_i/load_i sampled at edge N are visible on q_o, below_o, wrap_o, steps_o after edge N.
// No backpressure: the generator steps on every edge with en_i high; load_i overrides en_i.
module lfsr_prng #(
  parameter int unsigned WIDTH       = 10,
  parameter bit          FULL_PERIOD = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH:1]   seed_i,
  input  logic [WIDTH-1:0] threshold_i,
  output logic [WIDTH:1]   q_o,
  output logic             below_o,
  output logic             wrap_o,
  output logic [WIDTH:0]   steps_o
);

  // Only lengths with an entry in the tap table are supported.
  generate
    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
      $error("lfsr_prng: WIDTH must be in the range 3..16");
    end
  endgenerate

  // Maximal-length tap sets; bit n of Q maps to mask bit n-1.
  function automatic logic [15:0] tap_mask(input int unsigned w);
    logic [15:0] m;
    m = 16'h0000;
    case (w)
      3:       m = 16'h0006; // 3,2
      4:       m = 16'h000C; // 4,3
      5:       m = 16'h0014; // 5,3
      6:       m = 16'h0030; // 6,5
      7:       m = 16'h0060; // 7,6
      8:       m = 16'h00B8; // 8,6,5,4
      9:       m = 16'h0110; // 9,5
      10:      m = 16'h0240; // 10,7
      11:      m = 16'h0500; // 11,9
      12:      m = 16'h0829; // 12,6,4,1
      13:      m = 16'h100D; // 13,4,3,1
      14:      m = 16'h2015; // 14,5,3,1
      15:      m = 16'h6000; // 15,14
      16:      m = 16'hD008; // 16,15,13,4
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  localparam logic [15:0]    TAP_MASK_ALL = tap_mask(WIDTH);
  localparam logic [WIDTH:1] TAPS         = TAP_MASK_ALL[WIDTH-1:0];
  localparam logic [WIDTH:0] STEPS_MAX    = '1;

  logic [WIDTH:1] q_q, q_d;
  logic [WIDTH:1] start_q, start_d;
  logic [WIDTH:0] steps_q, steps_d;
  logic           wrap_q, wrap_d;
  logic           below_q, below_d;
  logic           fb;
  logic [WIDTH:1] q_step;

  // One LFSR step from the current state. The XNOR form makes all-zeros a legal state
  // (so reset to 0 starts the sequence) and all-ones the lock-up state, which is either
  // spliced into the cycle after 0111..1 or, in the classic form, kicked back to zero.
  always_comb begin
    fb     = ~^(q_q & TAPS);
    q_step = {q_q[WIDTH-1:1], fb};
    if (FULL_PERIOD) begin
      q_step[1] = fb ^ (&q_q[WIDTH-1:1]);
    end else if (&q_q) begin
      q_step = '0;
    end
  end

  // Next-state selection: load beats step beats hold; wrap is a single-cycle pulse.
  always_comb begin
    q_d     = q_q;
    start_d = start_q;
    steps_d = steps_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      q_d     = seed_i;
      start_d = seed_i;
      steps_d = '0;
    end else if (en_i) begin
      q_d = q_step;
      if (q_step == start_q) begin
        wrap_d  = 1'b1;
        steps_d = '0;
      end else if (steps_q != STEPS_MAX) begin
        steps_d = steps_q + 1'b1;
      end
    end
    // Compare against the state being registered so below_o lines up with q_o.
    below_d = (q_d < threshold_i);
  end

  // State registers; all period-tracking state clears asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q     <= '0;
      start_q <= '0;
      steps_q <= '0;
      wrap_q  <= 1'b0;
      below_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      start_q <= start_d;
      steps_q <= steps_d;
      wrap_q  <= wrap_d;
      below_q <= below_d;
    end
  end

  assign q_o     = q_q;
  assign wrap_o  = wrap_q;
  assign steps_o = steps_q;
  // While held in reset Q is zero, so the compare collapses to a non-zero threshold test.
  assign below_o = rst_ni ? below_q : (threshold_i != '0);

  // A wrap always restarts the step count.
  a_wrap_clears_steps : assert property (@(posedge clk_i) disable iff (!rst_ni)
    wrap_q |-> (steps_q == '0));

  // The shortest cycle is 7 states, so two returns to start can never be adjacent.
  a_no_back_to_back_wrap : assert property (@(posedge clk_i) disable iff (!rst_ni)
    wrap_q |=> !wrap_q);

endmodule

// File: tb/tb_lfsr_prng.sv
module tb_lfsr_prng;

  logic       clk_i = 1'b0;
  logic       rst_ni, en_i, load_i;
  logic [3:0] seed4, thr4;
  logic [9:0] seed10, thr10;

  logic [3:0]  q4f, q4c;
  logic [9:0]  q10f, q10c;
  logic        below4f, below4c, below10f, below10c;
  logic        wrap4f, wrap4c, wrap10f, wrap10c;
  logic [4:0]  steps4f, steps4c;
  logic [10:0] steps10f, steps10c;

  always #5 clk_i = ~clk_i;

  lfsr_prng #(.WIDTH(4), .FULL_PERIOD(1'b1)) u_w4f (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .load_i(load_i), .seed_i(seed4),
    .threshold_i(thr4), .q_o(q4f), .below_o(below4f), .wrap_o(wrap4f), .steps_o(steps4f));
  lfsr_prng #(.WIDTH(4), .FULL_PERIOD(1'b0)) u_w4c (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .load_i(load_i), .seed_i(seed4),
    .threshold_i(thr4), .q_o(q4c), .below_o(below4c), .wrap_o(wrap4c), .steps_o(steps4c));
  lfsr_prng #(.WIDTH(10), .FULL_PERIOD(1'b1)) u_w10f (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .load_i(load_i), .seed_i(seed10),
    .threshold_i(thr10), .q_o(q10f), .below_o(below10f), .wrap_o(wrap10f), .steps_o(steps10f));
  lfsr_prng #(.WIDTH(10), .FULL_PERIOD(1'b0)) u_w10c (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .load_i(load_i), .seed_i(seed10),
    .threshold_i(thr10), .q_o(q10c), .below_o(below10c), .wrap_o(wrap10c), .steps_o(steps10c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference model, one entry per instance: 0=W4 full, 1=W4 classic, 2=W10 full, 3=W10 classic.
  int W[4]  = '{4, 4, 10, 10};
  int FP[4] = '{1, 0, 1, 0};
  int mq[4], mstart[4], msteps[4];
  bit mwrap[4];

  typedef struct {
    int id;
    int q;
    bit below;
    bit wrap;
    int steps;
  } exp_t;
  exp_t sb_q[$];

  function automatic int lfsr_next(int q, int w, int fp);
    int t[4];
    int n;
    int fb;
    int low;
    int all;
    n = 0;
    t = '{0, 0, 0, 0};
    if (w == 4) begin
      t[0] = 4; t[1] = 3; n = 2;
    end else if (w == 10) begin
      t[0] = 10; t[1] = 7; n = 2;
    end
    fb = 1;
    for (int i = 0; i < n; i++) fb = fb ^ ((q >> (t[i] - 1)) & 1);
    low = (1 << (w - 1)) - 1;
    all = (1 << w) - 1;
    if (fp != 0) begin
      if ((q & low) == low) fb = fb ^ 1;
    end else if (q == all) begin
      return 0;
    end
    return ((q << 1) | fb) & all;
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 4; id++) begin
      mq[id] = 0; mstart[id] = 0; msteps[id] = 0; mwrap[id] = 1'b0;
    end
  endtask

  task automatic model_apply(input bit e, input bit l);
    exp_t x;
    int nq, smax, sd, th;
    for (int id = 0; id < 4; id++) begin
      sd   = (id < 2) ? int'(seed4) : int'(seed10);
      th   = (id < 2) ? int'(thr4) : int'(thr10);
      smax = (1 << (W[id] + 1)) - 1;
      if (l) begin
        mq[id] = sd; mstart[id] = sd; msteps[id] = 0; mwrap[id] = 1'b0;
      end else if (e) begin
        nq = lfsr_next(mq[id], W[id], FP[id]);
        if (nq == mstart[id]) begin
          mwrap[id] = 1'b1; msteps[id] = 0;
        end else begin
          mwrap[id] = 1'b0;
          if (msteps[id] < smax) msteps[id] = msteps[id] + 1;
        end
        mq[id] = nq;
      end else begin
        mwrap[id] = 1'b0;
      end
      x.id = id; x.q = mq[id]; x.below = (mq[id] < th); x.wrap = mwrap[id]; x.steps = msteps[id];
      sb_q.push_back(x);
    end
  endtask

  task automatic get_act(input int id, output logic [31:0] q, output logic [31:0] b,
                         output logic [31:0] w, output logic [31:0] s);
    case (id)
      0:       begin q = 32'(q4f);  b = 32'(below4f);  w = 32'(wrap4f);  s = 32'(steps4f);  end
      1:       begin q = 32'(q4c);  b = 32'(below4c);  w = 32'(wrap4c);  s = 32'(steps4c);  end
      2:       begin q = 32'(q10f); b = 32'(below10f); w = 32'(wrap10f); s = 32'(steps10f); end
      default: begin q = 32'(q10c); b = 32'(below10c); w = 32'(wrap10c); s = 32'(steps10c); end
    endcase
  endtask

  // Drive one cycle from a negedge, push the model result, compare after the next posedge.
  task automatic step_cycle(input bit e, input bit l);
    exp_t x;
    logic [31:0] aq, ab, aw, as;
    en_i = e; load_i = l;
    model_apply(e, l);
    @(posedge clk_i);
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        break;
      end
      x = sb_q.pop_front();
      get_act(x.id, aq, ab, aw, as);
      chk($sformatf("q[%0d]", x.id), aq, 32'(x.q));
      chk($sformatf("below[%0d]", x.id), ab, 32'(x.below));
      chk($sformatf("wrap[%0d]", x.id), aw, 32'(x.wrap));
      chk($sformatf("steps[%0d]", x.id), as, 32'(x.steps));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  exp_f[5];
    logic [3:0]  exp_c[5];
    logic [15:0] seen_f;
    int first_wrap_f, first_wrap_c, ones_c, wraps_c40, n_below;

    exp_f = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE};
    exp_c = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD};

    rst_ni = 1'b0; en_i = 1'b0; load_i = 1'b0;
    seed4 = 4'h0; seed10 = 10'h000; thr4 = 4'd3; thr10 = 10'h200;
    model_reset();

    // Reset state, including the combinational below while in reset.
    #12;
    chk("rst_q4f", 32'(q4f), 32'd0);
    chk("rst_q10c", 32'(q10c), 32'd0);
    chk("rst_wrap4f", 32'(wrap4f), 32'd0);
    chk("rst_steps10f", 32'(steps10f), 32'd0);
    chk("rst_below4f", 32'(below4f), 32'd1);
    thr4 = 4'd0;
    #1;
    chk("rst_below4f_thr0", 32'(below4f), 32'd0);
    thr4 = 4'd3;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Free run from reset: sequence start, first wrap position, state coverage.
    seen_f = '0; first_wrap_f = 0; first_wrap_c = 0; ones_c = 0;
    for (int k = 1; k <= 32; k++) begin
      step_cycle(1'b1, 1'b0);
      if (k <= 5) begin
        chk($sformatf("seq4f_%0d", k), 32'(q4f), 32'(exp_f[k-1]));
        chk($sformatf("seq4c_%0d", k), 32'(q4c), 32'(exp_c[k-1]));
      end
      if (k <= 16) seen_f[q4f] = 1'b1;
      if (wrap4f && first_wrap_f == 0) first_wrap_f = k;
      if (wrap4c && first_wrap_c == 0) first_wrap_c = k;
      if (q4c == 4'hF) ones_c++;
      if (k == 16) begin
        chk("wrap16_q4f", 32'(q4f), 32'd0);
        chk("wrap16_steps4f", 32'(steps4f), 32'd0);
      end
    end
    chk("first_wrap_4f", 32'(first_wrap_f), 32'd16);
    chk("first_wrap_4c", 32'(first_wrap_c), 32'd15);
    chk("states_seen_4f", 32'($countones(seen_f)), 32'd16);
    chk("ones_seen_4c", 32'(ones_c), 32'd0);

    // Load with en on the same edge; W4 gets the all-ones lock-up seed.
    seed4 = 4'hF; seed10 = 10'h155;
    step_cycle(1'b1, 1'b1);
    chk("load_q10f", 32'(q10f), 32'h155);
    chk("load_steps10f", 32'(steps10f), 32'd0);
    chk("load_q4c", 32'(q4c), 32'hF);

    wraps_c40 = 0; n_below = 0;
    for (int k = 1; k <= 1024; k++) begin
      step_cycle(1'b1, 1'b0);
      if (k == 1) chk("lockup_q4c", 32'(q4c), 32'd0);
      if (k <= 40 && wrap4c) wraps_c40++;
      if (k == 40) chk("sat_steps4c", 32'(steps4c), 32'd31);
      if (below10f) n_below++;
      if (k == 1023) begin
        chk("wrap1023_10c", 32'(wrap10c), 32'd1);
        chk("wrap1023_q10c", 32'(q10c), 32'h155);
        chk("nowrap1023_10f", 32'(wrap10f), 32'd0);
      end
      if (k == 1024) begin
        chk("wrap1024_10f", 32'(wrap10f), 32'd1);
        chk("wrap1024_q10f", 32'(q10f), 32'h155);
        chk("wrap1024_steps10f", 32'(steps10f), 32'd0);
      end
    end
    chk("wraps40_4c", 32'(wraps_c40), 32'd0);
    chk("below_count_10f", 32'(n_below), 32'd512);

    // Threshold change with en low still updates below on the next edge.
    chk("below_pre_10f", 32'(below10f), 32'd1);
    thr10 = 10'h000;
    step_cycle(1'b0, 1'b0);
    chk("below_thr0_10f", 32'(below10f), 32'd0);
    chk("hold_q10f", 32'(q10f), 32'h155);

    // Asynchronous reset between edges, then restart.
    thr10 = 10'h200;
    for (int k = 0; k < 3; k++) step_cycle(1'b1, 1'b0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk("arst_q4f", 32'(q4f), 32'd0);
    chk("arst_q10f", 32'(q10f), 32'd0);
    chk("arst_steps10f", 32'(steps10f), 32'd0);
    chk("arst_wrap10c", 32'(wrap10c), 32'd0);
    chk("arst_below10f", 32'(below10f), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step_cycle(1'b1, 1'b0);
    chk("restart_q4f", 32'(q4f), 32'd1);
    chk("restart_q10f", 32'(q10f), 32'd1);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
